aes_keyram_nkey: RTL

AES_KEYRAM_NKEY -- requirements
Module: aes_keyram_nkey

---
 rtl/aes_keyram_pkg.sv | 20 ++
 rtl/aes_keyram_bank.sv | 26 ++
 rtl/aes_keyram_nkey.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_keyram_pkg.sv
// aes_keyram_pkg: shared widths and write-FSM encoding
// for the multi-slot AES round-key RAM.
package aes_keyram_pkg;

  localparam int KEY_W      = 128;
  localparam int WR_W       = 64;
  localparam int AES128_NRK = 11;
  localparam int RND_W      = 4;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_HI   = 2'd1,
    WR_LO   = 2'd2
  } wr_state_e;

  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_keyram_bank.sv
// aes_keyram_bank: simple dual-port key storage,
// one write port and one registered read port.
module aes_keyram_bank #(
  parameter int DEPTH = 22,
  parameter int AW    = 5,
  parameter int DW    = 128
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Plain write plus registered read, no reset,
  // so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/aes_keyram_nkey.sv
// aes_keyram_nkey: NUM_SLOTS round-key sets loaded 64 bits
// at a time. Optional macro: AES_KEYRAM_WR_TIMEOUT_EN.
module aes_keyram_nkey
  import aes_keyram_pkg::*;
#(
  parameter int NUM_SLOTS = 2,
  parameter int NUM_RK    = AES128_NRK,
  parameter int TIMEOUT   = 255,
  localparam int SLOT_W   = slot_w(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 kill,
  input  logic                 en_wr,
  input  logic [WR_W-1:0]      key_round_wr,
  input  logic [SLOT_W-1:0]    wr_slot,
  input  logic                 rd_en,
  input  logic [SLOT_W-1:0]    rd_slot,
  input  logic [RND_W-1:0]     rd_round,
  output logic [KEY_W-1:0]     key_round_rd,
  output logic                 rd_valid,
  output logic [NUM_SLOTS-1:0] key_ready,
  output logic                 wr_idle,
  output logic                 wr_err_irq_pulse,
  output logic                 rd_err_irq_pulse
);

  localparam int DEPTH  = NUM_SLOTS * NUM_RK;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOT_N = 2 ** SLOT_W;

  // Legal-index maps: a bit per encodable slot/round.
  localparam logic [SLOT_N-1:0] SLOT_MAP =
    SLOT_N'((1 << NUM_SLOTS) - 1);
  localparam logic [15:0] RK_MAP =
    16'((1 << NUM_RK) - 1);
  localparam logic [RND_W-1:0] LAST_RND =
    RND_W'(NUM_RK - 1);

  wr_state_e         state_q;
  wr_state_e         state_d;
  logic [SLOT_W-1:0] slot_q;
  logic [RND_W-1:0]  rnd_q;
  logic [WR_W-1:0]   hi_q;

  logic start;
  logic hi_ld;
  logic bank_we;
  logic done;
  logic wr_err;
  logic timeout;
  logic last_rnd;
  logic wr_slot_ok;

  logic [SLOT_N-1:0] ready_ext;
  logic [SLOT_N-1:0] ready_nx;

  logic              rd_ok;
  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     wr_addr;
  logic [KEY_W-1:0]  bank_rdata;
  logic              zero_q;

  assign ready_ext  = SLOT_N'(key_ready);
  assign wr_slot_ok = SLOT_MAP[wr_slot];
  assign last_rnd   = (rnd_q == LAST_RND);
  assign wr_idle    = (state_q == WR_IDLE);

`ifdef AES_KEYRAM_WR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1) + 1;

  logic [TO_W-1:0] idle_cnt_q;

  assign timeout = (state_q != WR_IDLE) && !en_wr &&
                   (idle_cnt_q == TO_W'(TIMEOUT));

  // Count consecutive idle cycles inside a set.
  always_ff @(posedge clk) begin
    if (kill || wr_idle || en_wr || timeout)
      idle_cnt_q <= '0;
    else
      idle_cnt_q <= idle_cnt_q + 1'b1;
  end
`else
  // No watchdog: the FSM waits for the next word forever.
  assign timeout = (TIMEOUT < 0);
`endif

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (kill) state_q <= WR_IDLE;
    else      state_q <= state_d;
  end

  // Write FSM next state; no en_wr means hold.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WR_IDLE:
        if (en_wr && wr_slot_ok) state_d = WR_LO;
      WR_HI:
        if (en_wr)        state_d = WR_LO;
        else if (timeout) state_d = WR_IDLE;
      WR_LO:
        if (en_wr)        state_d = last_rnd ? WR_IDLE : WR_HI;
        else if (timeout) state_d = WR_IDLE;
      default:
        state_d = WR_IDLE;
    endcase
  end

  // Write FSM per-state actions.
  always_comb begin
    start   = 1'b0;
    hi_ld   = 1'b0;
    bank_we = 1'b0;
    done    = 1'b0;
    wr_err  = 1'b0;
    unique case (state_q)
      WR_IDLE: begin
        start  = en_wr & wr_slot_ok;
        wr_err = en_wr & ~wr_slot_ok;
      end
      WR_HI: begin
        hi_ld  = en_wr;
        wr_err = timeout;
      end
      WR_LO: begin
        bank_we = en_wr;
        done    = en_wr & last_rnd;
        wr_err  = timeout;
      end
      default: ;
    endcase
  end

  // Slot flags: cleared when a set starts, set when it lands.
  always_comb begin
    ready_nx = ready_ext;
    if (start) ready_nx[wr_slot] = 1'b0;
    if (done)  ready_nx[slot_q]  = 1'b1;
  end

  // Control registers for the write side.
  always_ff @(posedge clk) begin
    if (kill) begin
      key_ready        <= '0;
      wr_err_irq_pulse <= 1'b0;
    end else begin
      key_ready        <= ready_nx[NUM_SLOTS-1:0];
      wr_err_irq_pulse <= wr_err;
    end
  end

  // Set datapath: captured slot, round index, pending HI half.
  always_ff @(posedge clk) begin
    if (start) begin
      slot_q <= wr_slot;
      rnd_q  <= '0;
      hi_q   <= key_round_wr;
    end
    if (hi_ld) hi_q <= key_round_wr;
    if (bank_we && !last_rnd) rnd_q <= rnd_q + 1'b1;
  end

  assign wr_addr = AW'(slot_q) * AW'(NUM_RK) + AW'(rnd_q);

  assign rd_ok = SLOT_MAP[rd_slot] & RK_MAP[rd_round] &
                 ready_ext[rd_slot];
  assign rd_addr = rd_ok ?
    AW'(rd_slot) * AW'(NUM_RK) + AW'(rd_round) : '0;

  aes_keyram_bank #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (KEY_W)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we & ~kill),
    .waddr (wr_addr),
    .wdata ({hi_q, key_round_wr}),
    .re    (rd_en & rd_ok),
    .raddr (rd_addr),
    .rdata (bank_rdata)
  );

  // Read status; zero_q masks RAM data after errors and reset.
  always_ff @(posedge clk) begin
    if (kill) begin
      rd_valid         <= 1'b0;
      rd_err_irq_pulse <= 1'b0;
      zero_q           <= 1'b1;
    end else begin
      rd_valid         <= rd_en;
      rd_err_irq_pulse <= rd_en & ~rd_ok;
      if (rd_en) zero_q <= ~rd_ok;
    end
  end

  assign key_round_rd = zero_q ? '0 : bank_rdata;

endmodule
